// File: rtl/rca_word_seq.sv
// Wide add/subtract built by stepping one 8-bit ripple-carry adder across NBYTES byte lanes, LSB first.
// Optional subtract support (op_sub port) is enabled by defining RCA_SEQ_SUB_EN.
module rca_word_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef RCA_SEQ_SUB_EN
  input  logic                op_sub,
`endif
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          sub_in;
  logic [7:0]    add_a, add_b, add_s;
  logic          add_co;

`ifdef RCA_SEQ_SUB_EN
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
`endif

  // Shared byte adder: B is inverted for subtract, carry_q supplies the +1 on the first byte.
  always_comb begin
    logic c;
    add_a = a_q[8*idx_q +: 8];
    add_b = b_q[8*idx_q +: 8] ^ {8{sub_q}};
    add_s = 8'd0;
    c     = carry_q;
    for (int i = 0; i < 8; i++) begin
      add_s[i] = add_a[i] ^ add_b[i] ^ c;
      c        = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
    end
    add_co = c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub_in;
          carry_d = sub_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[8*idx_q +: 8] = add_s;
        carry_d             = add_co;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_co;
          ovf_d   = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/rca_word_seq.md
# rca_word_seq

Multi-cycle sequencer that computes wide add/subtract results by time-multiplexing a single 8-bit ripple-carry adder (Ripple_Carry_Addr_8bit) over NBYTES cycles, one byte per cycle, LSB first. The block latches full-width operands on a start handshake and walks the byte index. It threads the carry through a register between passes and assembles the result. It sits between the ALU-level control and the shared 8-bit adder datapath, giving wide arithmetic at byte-adder cost.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 1..16; word width W = 8*NBYTES.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- op_sub  in  1  1 = A-B, 0 = A+B. Port exists only with RCA_SEQ_SUB_EN.
- a  in  W  operand A; sampled on the accepting edge only.
- b  in  W  operand B; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse in DONE; result valid.
- sum  out  W  result register.
- cout  out  1  final carry out of byte NBYTES-1; for subtract, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow of the full word.

## Operation
- Internal registers:
  - a_r, b_r (W bits), latched on accept.
  - carry_r (1 bit).
  - idx: byte counter of width clog2(NBYTES), minimum 1 bit.
  - sub_r.
- One adder instance:
  - A = a_r[8*idx +: 8].
  - B = b_r[8*idx +: 8], XORed with {8{sub_r}}.
  - cin = carry_r.
- FSM: IDLE, RUN, DONE.
  - IDLE: if start, then a_r<=a, b_r<=b, sub_r<=op_sub (0 without macro), carry_r<=sub_r value (1 for subtract, else 0), idx<=0, go to RUN.
  - RUN: each edge writes sum[8*idx +: 8]<=S and carry_r<=adder cout.
    - If idx==NBYTES-1: cout<=adder cout; ovf<=(A[7]==Beff[7]) && (S[7]!=A[7]), where Beff is the post-XOR B; go to DONE.
    - Otherwise idx<=idx+1.
  - DONE: exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE; changes on a/b/op_sub after accept have no effect.
- sum bytes update progressively during RUN. Intermediate values are not valid; only done qualifies sum/cout/ovf.
- sum/cout/ovf hold their values from DONE until the next accepted start overwrites them.
- Wrap-around: results are modulo 2^W; carry beyond the MSB appears only on cout.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, idx 0, carry_r 0.
- rst has priority over every other input on any edge. Reset mid-RUN aborts the operation, and the next cycle shows reset values with no done pulse.
- Accept at edge k. busy is high during cycles k..k+NBYTES-1, i.e. after edges k through k+NBYTES-1.
- Byte i is written at edge k+1+i. The last byte is written at edge k+NBYTES, with state→DONE.
- done is high for exactly the cycle after edge k+NBYTES; latency = NBYTES+1 edges from accept to done sample.
- Back-to-back: start held high is accepted at edges k, k+NBYTES+2, … (one IDLE cycle between operations); throughput is one operation per NBYTES+2 cycles.
- NBYTES=1: single RUN cycle, then DONE.
- Adder path is combinational within one cycle. There is no combinational path from start/a/b to any output.

## Configuration
- RCA_SEQ_SUB_EN defined: op_sub port present; subtract by B inversion and initial carry 1; cout=1 means no borrow.
- Not defined: op_sub port absent, sub_r tied 0, add only; initial carry always 0.

## Test plan
- NBYTES=4, a=0x000000FF, b=0x00000001, start pulse → sum=0x00000100, cout=0, ovf=0; done one cycle, sampled 5 edges after accept edge; busy high exactly 4 cycles.
- a=0xFFFFFFFF, b=0x00000001 → sum=0x00000000, cout=1, ovf=0. a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, ovf=1.
- Macro on: a=0x00000005, b=0x00000007, op_sub=1 → sum=0xFFFFFFFE, cout=0, ovf=0. a=0x80000000, b=0x00000001, op_sub=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Accept a=0x11111111, b=0x22222222. During RUN, change a/b, toggle op_sub and pulse start → result 0x33333333, single done, no second operation.
- Assert rst at the edge writing byte 2 → next cycle busy=0, done=0, sum=0, cout=0, ovf=0. A new start one cycle later completes normally.
- start held high for 20 cycles with fixed operands → done pulses at accept+5, +11, +17 edges; results identical each time.
